// File: rtl/store_queue.sv
// In-order store queue: allocate at dispatch, resolve at execute, commit at retire,
// drain committed stores to memory, and expose an age-ordered view for load forwarding.
module store_queue #(
    parameter int unsigned SQ_SIZE = 8,
    localparam int unsigned IW = $clog2(SQ_SIZE),
    localparam int unsigned PW = IW + 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       alloc_valid,
    output logic                       alloc_ready,
    output logic [IW-1:0]              alloc_idx,
    input  logic                       exec_valid,
    input  logic [IW-1:0]              exec_idx,
    input  logic [31:0]                exec_addr,
    input  logic [31:0]                exec_data,
    input  logic                       commit_valid,
    input  logic                       flush,
    output logic                       mem_req_valid,
    input  logic                       mem_req_ready,
    output logic [31:0]                mem_req_addr,
    output logic [31:0]                mem_req_data,
    output logic [SQ_SIZE-1:0]         sq_valid,
    output logic [SQ_SIZE-1:0][31:0]   sq_addr,
    output logic [SQ_SIZE-1:0][31:0]   sq_data,
    output logic [PW-1:0]              count,
    output logic                       full,
    output logic                       empty
);

    logic [PW-1:0] head_q, head_d, cptr_q, cptr_d, tail_q, tail_d;
    logic [SQ_SIZE-1:0] occupied_q, occupied_d;
    logic [SQ_SIZE-1:0] executed_q, executed_d;
    logic [SQ_SIZE-1:0] committed_q, committed_d;
    logic [SQ_SIZE-1:0][31:0] addr_q, addr_d, data_q, data_d;

    logic [IW-1:0] head_slot, cptr_slot, tail_slot;
    logic alloc_fire, exec_fire, commit_fire, drain_fire;
    logic [PW-1:0] flush_span;
    logic [SQ_SIZE-1:0] in_flush;

    assign head_slot = head_q[IW-1:0];
    assign cptr_slot = cptr_q[IW-1:0];
    assign tail_slot = tail_q[IW-1:0];

    assign full        = (head_slot == tail_slot) && (head_q[IW] != tail_q[IW]);
    assign empty       = (head_q == tail_q);
    assign count       = tail_q - head_q;
    assign alloc_ready = !full;
    assign alloc_idx   = tail_slot;

    assign mem_req_valid = occupied_q[head_slot] && committed_q[head_slot];
    assign mem_req_addr  = addr_q[head_slot];
    assign mem_req_data  = data_q[head_slot];

    assign alloc_fire  = alloc_valid && !full && !flush;
    assign exec_fire   = exec_valid && !flush && occupied_q[exec_idx] && !committed_q[exec_idx];
    assign commit_fire = commit_valid && (cptr_q != tail_q) && executed_q[cptr_slot];
    assign drain_fire  = mem_req_valid && mem_req_ready;

    // A commit in the same cycle as a flush is applied first, so the flush window
    // starts at the post-commit pointer.
    assign cptr_d     = commit_fire ? cptr_q + PW'(1) : cptr_q;
    assign flush_span = tail_q - cptr_d;

    for (genvar i = 0; i < SQ_SIZE; i++) begin : g_slot
        logic [IW-1:0] view_slot;

        assign in_flush[i] = {1'b0, IW'(i) - cptr_d[IW-1:0]} < flush_span;

        // Forwarding view position i maps to the i-th slot after head.
        assign view_slot   = head_slot + IW'(i);
        assign sq_valid[i] = (PW'(i) < count) && occupied_q[view_slot]
                             && executed_q[view_slot];
        assign sq_addr[i]  = sq_valid[i] ? addr_q[view_slot] : '0;
        assign sq_data[i]  = sq_valid[i] ? data_q[view_slot] : '0;
    end

    always_comb begin
        head_d      = head_q;
        tail_d      = tail_q;
        occupied_d  = occupied_q;
        executed_d  = executed_q;
        committed_d = committed_q;
        addr_d      = addr_q;
        data_d      = data_q;

        if (exec_fire) begin
            addr_d[exec_idx]     = exec_addr;
            data_d[exec_idx]     = exec_data;
            executed_d[exec_idx] = 1'b1;
        end

        if (commit_fire) begin
            committed_d[cptr_slot] = 1'b1;
        end

        if (alloc_fire) begin
            occupied_d[tail_slot]  = 1'b1;
            executed_d[tail_slot]  = 1'b0;
            committed_d[tail_slot] = 1'b0;
            tail_d                 = tail_q + PW'(1);
        end

        if (drain_fire) begin
            occupied_d[head_slot]  = 1'b0;
            executed_d[head_slot]  = 1'b0;
            committed_d[head_slot] = 1'b0;
            addr_d[head_slot]      = '0;
            data_d[head_slot]      = '0;
            head_d                 = head_q + PW'(1);
        end

        if (flush) begin
            occupied_d = occupied_d & ~in_flush;
            executed_d = executed_d & ~in_flush;
            tail_d     = cptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q      <= '0;
            cptr_q      <= '0;
            tail_q      <= '0;
            occupied_q  <= '0;
            executed_q  <= '0;
            committed_q <= '0;
            addr_q      <= '0;
            data_q      <= '0;
        end else begin
            head_q      <= head_d;
            cptr_q      <= cptr_d;
            tail_q      <= tail_d;
            occupied_q  <= occupied_d;
            executed_q  <= executed_d;
            committed_q <= committed_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
        end
    end

endmodule

// File: tb/tb_store_queue.sv
// Bench for store_queue: directed scenarios plus a randomized run, all checked against
// an age-ordered queue model of the store queue.
module tb_store_queue;
    localparam int N  = 8;
    localparam int IW = 3;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 alloc_valid;
    logic                 alloc_ready;
    logic [IW-1:0]        alloc_idx;
    logic                 exec_valid;
    logic [IW-1:0]        exec_idx;
    logic [31:0]          exec_addr;
    logic [31:0]          exec_data;
    logic                 commit_valid;
    logic                 flush;
    logic                 mem_req_valid;
    logic                 mem_req_ready;
    logic [31:0]          mem_req_addr;
    logic [31:0]          mem_req_data;
    logic [N-1:0]         sq_valid;
    logic [N-1:0][31:0]   sq_addr;
    logic [N-1:0][31:0]   sq_data;
    logic [IW:0]          count;
    logic                 full;
    logic                 empty;

    int n_tests = 0;
    int n_fail  = 0;

    store_queue #(.SQ_SIZE(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .alloc_valid  (alloc_valid),
        .alloc_ready  (alloc_ready),
        .alloc_idx    (alloc_idx),
        .exec_valid   (exec_valid),
        .exec_idx     (exec_idx),
        .exec_addr    (exec_addr),
        .exec_data    (exec_data),
        .commit_valid (commit_valid),
        .flush        (flush),
        .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready),
        .mem_req_addr (mem_req_addr),
        .mem_req_data (mem_req_data),
        .sq_valid     (sq_valid),
        .sq_addr      (sq_addr),
        .sq_data      (sq_data),
        .count        (count),
        .full         (full),
        .empty        (empty)
    );

    always #5 clk = ~clk;

    // Reference model: live stores oldest-first, plus the head slot and committed prefix length.
    typedef struct {
        int          slot;
        bit          ex;
        bit          cm;
        logic [31:0] addr;
        logic [31:0] data;
    } ent_t;

    ent_t mq[$];
    int   m_head;
    int   m_ncomm;

    logic [N-1:0]       exp_sq_valid;
    logic [N-1:0][31:0] exp_sq_addr;
    logic [N-1:0][31:0] exp_sq_data;
    logic [IW:0]        exp_count;
    logic               exp_full;
    logic [IW-1:0]      exp_idx;
    logic               exp_mv;
    logic [31:0]        exp_maddr;
    logic [31:0]        exp_mdata;

    task automatic model_edge();
        int  sz0;
        bit  do_drain;
        bit  do_commit;
        ent_t e;
        if (rst) begin
            mq.delete();
            m_head  = 0;
            m_ncomm = 0;
            return;
        end
        sz0       = mq.size();
        do_drain  = (sz0 > 0) && mq[0].cm && mem_req_ready;
        do_commit = commit_valid && (m_ncomm < sz0) && mq[m_ncomm].ex;
        if (exec_valid && !flush) begin
            for (int k = 0; k < sz0; k++) begin
                if (mq[k].slot == int'(exec_idx) && !mq[k].cm) begin
                    mq[k].ex   = 1'b1;
                    mq[k].addr = exec_addr;
                    mq[k].data = exec_data;
                end
            end
        end
        if (do_commit) begin
            mq[m_ncomm].cm = 1'b1;
            m_ncomm++;
        end
        if (flush) begin
            while (mq.size() > m_ncomm) void'(mq.pop_back());
        end else if (alloc_valid && sz0 < N) begin
            e.slot = (m_head + sz0) % N;
            e.ex   = 1'b0;
            e.cm   = 1'b0;
            e.addr = '0;
            e.data = '0;
            mq.push_back(e);
        end
        if (do_drain) begin
            void'(mq.pop_front());
            m_ncomm--;
            m_head = (m_head + 1) % N;
        end
    endtask

    task automatic model_expect();
        exp_sq_valid = '0;
        exp_sq_addr  = '0;
        exp_sq_data  = '0;
        for (int i = 0; i < mq.size(); i++) begin
            if (mq[i].ex) begin
                exp_sq_valid[i] = 1'b1;
                exp_sq_addr[i]  = mq[i].addr;
                exp_sq_data[i]  = mq[i].data;
            end
        end
        exp_count = (IW+1)'(mq.size());
        exp_full  = (mq.size() == N);
        exp_idx   = IW'((m_head + mq.size()) % N);
        exp_mv    = (mq.size() > 0) && mq[0].cm;
        exp_maddr = exp_mv ? mq[0].addr : '0;
        exp_mdata = exp_mv ? mq[0].data : '0;
    endtask

    task automatic idle_inputs();
        rst           = 1'b0;
        alloc_valid   = 1'b0;
        exec_valid    = 1'b0;
        exec_idx      = '0;
        exec_addr     = '0;
        exec_data     = '0;
        commit_valid  = 1'b0;
        flush         = 1'b0;
        mem_req_ready = 1'b0;
    endtask

    // Model and DUT both advance on this edge; outputs are sampled 1 time unit later.
    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if ({alloc_ready, empty, full, count, mem_req_valid, alloc_idx} !== {1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 3'd0}) begin
            n_fail++;
            $display("FAIL reset_status got rdy=%b emp=%b full=%b cnt=%0d mv=%b idx=%0d exp 1 1 0 0 0 0",
                     alloc_ready, empty, full, count, mem_req_valid, alloc_idx);
        end
        n_tests++;
        if (sq_valid !== '0 || sq_addr !== '0 || sq_data !== '0) begin
            n_fail++;
            $display("FAIL reset_view got valid=%b exp 0 (addr/data also exp 0)", sq_valid);
        end
    endtask

    task automatic test_exec_forward();
        do_reset();
        alloc_valid = 1'b1;
        tick();
        alloc_valid = 1'b0;
        exec_valid  = 1'b1;
        exec_idx    = 3'd0;
        exec_addr   = 32'h100;
        exec_data   = 32'hAA;
        tick();
        exec_valid = 1'b0;
        n_tests++;
        if ({sq_valid[0], sq_addr[0], sq_data[0], count} !== {1'b1, 32'h100, 32'hAA, 4'd1}) begin
            n_fail++;
            $display("FAIL exec_forward got v=%b a=%h d=%h cnt=%0d exp 1 100 aa 1",
                     sq_valid[0], sq_addr[0], sq_data[0], count);
        end
    endtask

    task automatic test_full();
        do_reset();
        alloc_valid = 1'b1;
        for (int i = 0; i < N; i++) begin
            n_tests++;
            if (alloc_idx !== IW'(i)) begin
                n_fail++;
                $display("FAIL full_alloc_idx got %0d exp %0d", alloc_idx, i);
            end
            tick();
        end
        n_tests++;
        if ({full, alloc_ready, count} !== {1'b1, 1'b0, 4'd8}) begin
            n_fail++;
            $display("FAIL full_flags got full=%b rdy=%b cnt=%0d exp 1 0 8", full, alloc_ready, count);
        end
        tick();
        alloc_valid = 1'b0;
        n_tests++;
        if (count !== 4'd8 || full !== 1'b1) begin
            n_fail++;
            $display("FAIL full_ninth_alloc got cnt=%0d full=%b exp 8 1", count, full);
        end
    endtask

    task automatic test_drain_stall();
        int drained;
        do_reset();
        alloc_valid = 1'b1;
        repeat (3) tick();
        alloc_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            exec_valid = 1'b1;
            exec_idx   = IW'(i);
            exec_addr  = 32'h200 + 32'(i * 4);
            exec_data  = 32'hD0 + 32'(i);
            tick();
        end
        exec_valid   = 1'b0;
        commit_valid = 1'b1;
        repeat (3) tick();
        commit_valid = 1'b0;
        for (int c = 0; c < 2; c++) begin
            n_tests++;
            if ({mem_req_valid, mem_req_addr, mem_req_data} !== {1'b1, 32'h200, 32'hD0}) begin
                n_fail++;
                $display("FAIL stall_hold got v=%b a=%h d=%h exp 1 200 d0",
                         mem_req_valid, mem_req_addr, mem_req_data);
            end
            tick();
        end
        mem_req_ready = 1'b1;
        drained = 0;
        for (int c = 0; c < 6 && drained < 3; c++) begin
            if (mem_req_valid) begin
                n_tests++;
                if (mem_req_addr !== 32'h200 + 32'(drained * 4) || mem_req_data !== 32'hD0 + 32'(drained)) begin
                    n_fail++;
                    $display("FAIL drain_order got a=%h d=%h exp a=%h d=%h", mem_req_addr, mem_req_data,
                             32'h200 + 32'(drained * 4), 32'hD0 + 32'(drained));
                end
                drained++;
            end
            tick();
        end
        mem_req_ready = 1'b0;
        n_tests++;
        if (drained != 3 || empty !== 1'b1) begin
            n_fail++;
            $display("FAIL drain_done got drained=%0d empty=%b exp 3 1", drained, empty);
        end
    endtask

    task automatic test_flush();
        bit seen;
        do_reset();
        alloc_valid = 1'b1;
        repeat (3) tick();
        alloc_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            exec_valid = 1'b1;
            exec_idx   = IW'(i);
            exec_addr  = 32'h300 + 32'(i);
            exec_data  = 32'h50 + 32'(i);
            tick();
        end
        exec_valid   = 1'b0;
        commit_valid = 1'b1;
        tick();
        commit_valid = 1'b0;
        flush        = 1'b1;
        alloc_valid  = 1'b1;
        tick();
        flush       = 1'b0;
        alloc_valid = 1'b0;
        n_tests++;
        if ({count, alloc_idx, sq_valid} !== {4'd1, 3'd1, 8'b0000_0001}) begin
            n_fail++;
            $display("FAIL flush_state got cnt=%0d idx=%0d valid=%b exp 1 1 00000001",
                     count, alloc_idx, sq_valid);
        end
        mem_req_ready = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 4 && !seen; c++) begin
            if (mem_req_valid) begin
                seen = 1'b1;
                n_tests++;
                if (mem_req_addr !== 32'h300 || mem_req_data !== 32'h50) begin
                    n_fail++;
                    $display("FAIL flush_survivor got a=%h d=%h exp 300 50", mem_req_addr, mem_req_data);
                end
            end
            tick();
        end
        mem_req_ready = 1'b0;
        n_tests++;
        if (!seen || empty !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_drain got seen=%b empty=%b exp 1 1", seen, empty);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        alloc_valid = 1'b1;
        repeat (N) tick();
        alloc_valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            exec_valid = 1'b1;
            exec_idx   = IW'(i);
            exec_addr  = 32'h1000 + 32'(i);
            exec_data  = 32'h7000 + 32'(i);
            tick();
        end
        exec_valid   = 1'b0;
        commit_valid = 1'b1;
        repeat (N) tick();
        commit_valid  = 1'b0;
        mem_req_ready = 1'b1;
        repeat (6) tick();
        mem_req_ready = 1'b0;
        n_tests++;
        if (count !== 4'd2 || alloc_idx !== 3'd0) begin
            n_fail++;
            $display("FAIL wrap_after_drain got cnt=%0d idx=%0d exp 2 0", count, alloc_idx);
        end
        alloc_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (alloc_idx !== IW'(i)) begin
                n_fail++;
                $display("FAIL wrap_alloc_idx got %0d exp %0d", alloc_idx, i);
            end
            tick();
        end
        alloc_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exec_valid = 1'b1;
            exec_idx   = IW'(i);
            exec_addr  = 32'h2000 + 32'(i);
            exec_data  = 32'h8000 + 32'(i);
            tick();
        end
        exec_valid = 1'b0;
        n_tests++;
        if ({sq_valid, sq_addr[0], sq_addr[1], sq_addr[2], sq_addr[5]} !==
            {8'b0011_1111, 32'h1006, 32'h1007, 32'h2000, 32'h2003}) begin
            n_fail++;
            $display("FAIL wrap_age_order got valid=%b a0=%h a1=%h a2=%h a5=%h exp 00111111 1006 1007 2000 2003",
                     sq_valid, sq_addr[0], sq_addr[1], sq_addr[2], sq_addr[5]);
        end
        model_expect();
        n_tests++;
        if (sq_addr !== exp_sq_addr || sq_data !== exp_sq_data) begin
            n_fail++;
            $display("FAIL wrap_view_model got a=%h exp a=%h", sq_addr, exp_sq_addr);
        end
    endtask

    task automatic test_reset_mid_drain();
        do_reset();
        alloc_valid = 1'b1;
        repeat (N) tick();
        alloc_valid = 1'b0;
        exec_valid  = 1'b1;
        exec_idx    = 3'd0;
        exec_addr   = 32'h4000;
        exec_data   = 32'h1;
        tick();
        exec_valid   = 1'b0;
        commit_valid = 1'b1;
        tick();
        commit_valid = 1'b0;
        n_tests++;
        if ({full, mem_req_valid} !== 2'b11) begin
            n_fail++;
            $display("FAIL pre_rst got full=%b mv=%b exp 1 1", full, mem_req_valid);
        end
        rst           = 1'b1;
        mem_req_ready = 1'b0;
        tick();
        rst = 1'b0;
        n_tests++;
        if ({alloc_ready, empty, full, count, mem_req_valid, alloc_idx, sq_valid} !==
            {1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 3'd0, 8'd0} || sq_addr !== '0 || sq_data !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_drain got rdy=%b emp=%b full=%b cnt=%0d mv=%b idx=%0d valid=%b exp 1 1 0 0 0 0 0",
                     alloc_ready, empty, full, count, mem_req_valid, alloc_idx, sq_valid);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int cyc = 0; cyc < 2000; cyc++) begin
            rst          = ($urandom_range(0, 199) == 0);
            alloc_valid  = ($urandom_range(0, 1) == 1);
            commit_valid = ($urandom_range(0, 9) < 4);
            flush        = ($urandom_range(0, 19) == 0);
            mem_req_ready = ($urandom_range(0, 1) == 1);
            exec_valid   = ($urandom_range(0, 9) < 6);
            if (mq.size() > 0 && $urandom_range(0, 3) != 0)
                exec_idx = IW'(mq[$urandom_range(0, mq.size() - 1)].slot);
            else
                exec_idx = IW'($urandom_range(0, N - 1));
            exec_addr = $urandom();
            exec_data = $urandom();
            tick();
            model_expect();
            n_tests++;
            if ({alloc_ready, full, empty, count, alloc_idx} !==
                {!exp_full, exp_full, exp_count == 0, exp_count, exp_idx}) begin
                n_fail++;
                $display("FAIL rand_status cyc=%0d got rdy=%b full=%b emp=%b cnt=%0d idx=%0d exp cnt=%0d idx=%0d",
                         cyc, alloc_ready, full, empty, count, alloc_idx, exp_count, exp_idx);
            end
            n_tests++;
            if (mem_req_valid !== exp_mv ||
                (exp_mv && (mem_req_addr !== exp_maddr || mem_req_data !== exp_mdata))) begin
                n_fail++;
                $display("FAIL rand_mem_req cyc=%0d got v=%b a=%h d=%h exp v=%b a=%h d=%h", cyc,
                         mem_req_valid, mem_req_addr, mem_req_data, exp_mv, exp_maddr, exp_mdata);
            end
            n_tests++;
            if (sq_valid !== exp_sq_valid || sq_addr !== exp_sq_addr || sq_data !== exp_sq_data) begin
                n_fail++;
                $display("FAIL rand_view cyc=%0d got valid=%b exp valid=%b", cyc, sq_valid, exp_sq_valid);
            end
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        mq.delete();
        m_head  = 0;
        m_ncomm = 0;
        test_reset();
        test_exec_forward();
        test_full();
        test_drain_stall();
        test_flush();
        test_wrap();
        test_reset_mid_drain();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/store_queue.md
STORE_QUEUE -- requirements
Module: store_queue

Interface
REQ-001 SHALL have parameter SQ_SIZE, default 8, entry count (power of 2, >=2).
REQ-002 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have alloc_valid in 1 / alloc_ready out 1 / alloc_idx out log2(SQ_SIZE) (dispatch allocates a store entry; alloc_idx = tail slot).
REQ-005 SHALL have exec_valid in 1 / exec_idx in log2(SQ_SIZE) / exec_addr in 32 / exec_data in 32 (store AGU writes resolved address and data).
REQ-006 SHALL have commit_valid in 1 (retire marks the oldest uncommitted store committed).
REQ-007 SHALL have flush in 1 (discard all uncommitted entries).
REQ-008 SHALL have mem_req_valid out 1 / mem_req_ready in 1 / mem_req_addr out 32 / mem_req_data out 32 (drain to data memory).
REQ-009 SHALL have sq_valid out SQ_SIZE / sq_addr out 32 x SQ_SIZE / sq_data out 32 x SQ_SIZE (age-ordered forwarding view for the load disambiguation search).
REQ-010 SHALL have count out log2(SQ_SIZE)+1, full out 1, empty out 1.

Function
REQ-011 SHALL keep head, commit and tail pointers, each log2(SQ_SIZE)+1 bits with a wrap bit; slot index = low bits; full when low bits equal and wrap bits differ.
REQ-012 SHALL give each entry: occupied, executed, committed, addr[31:0], data[31:0].
REQ-013 SHALL assert alloc_ready = !full from registered state only (no same-cycle bypass from a drain).
REQ-014 SHALL, on alloc_valid && alloc_ready && !flush, set occupied, clear executed/committed at tail slot and increment tail; alloc_idx = tail slot in that cycle.
REQ-015 SHALL, on exec_valid to an occupied, uncommitted slot, latch addr/data and set executed; writes to unoccupied slots ignored.
REQ-016 SHALL, on commit_valid when commit != tail and slot at commit is executed, set committed and increment commit; otherwise commit ignored.
REQ-017 SHALL drive mem_req_valid = slot at head occupied && committed, with mem_req_addr/data from that slot, stable until handshake.
REQ-018 SHALL, on mem_req_valid && mem_req_ready, clear the head slot and increment head.
REQ-019 SHALL drive sq_* rotated by head: element i = i-th oldest occupied entry (i = 0 oldest, SQ_SIZE-1 newest position); sq_valid[i] = occupied && executed; unused positions have sq_valid=0, addr/data=0.
REQ-020 SHALL make exec writes visible on sq_* one cycle after exec_valid (registered state only).
REQ-021 SHALL, on flush, clear occupied in every slot from commit to tail-1 and set tail = commit in the same edge; committed entries retained and drain continues.
REQ-022 SHALL give flush priority over alloc and exec in the same cycle; simultaneous commit processed before flush (committed entry survives).
REQ-023 SHALL permit alloc, exec, commit and drain in one cycle; count = tail - head (modular, wrap-aware).
REQ-024 SHALL never wrap tail past head; alloc while full is ignored.

Reset
REQ-025 SHALL on rst set head=commit=tail=0, clear all occupied/executed/committed, addr/data=0.
REQ-026 SHALL after reset drive alloc_ready=1, empty=1, full=0, count=0, mem_req_valid=0, sq_valid=0, sq_addr/sq_data=0, alloc_idx=0.
REQ-027 SHALL let rst mid-drain drop mem_req_valid next cycle regardless of mem_req_ready.

Verification
REQ-028 Alloc 1 entry, exec addr=0x100 data=0xAA -> next cycle sq_valid[0]=1, sq_addr[0]=0x100, sq_data[0]=0xAA, count=1.
REQ-029 Alloc 8 with mem_req_ready=0 -> full=1, alloc_ready=0; 9th alloc ignored, count stays 8.
REQ-030 Exec+commit 3 stores, mem_req_ready=0 for 2 cycles then 1 -> first request held stable, then 3 drains in order, empty=1.
REQ-031 Allocate 3, commit 1, flush -> tail=commit, count=1, committed store still drains; concurrent alloc ignored.
REQ-032 Drain 6 of 8 then alloc 4 (wrap) -> sq_* still age-ordered (oldest at index 0), alloc_idx wraps 7->0.
REQ-033 Assert rst with full queue and mem_req_valid=1 -> next cycle all outputs at reset values of REQ-026.
